// File: rtl/core_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM encoding, reset constants
// and instruction field positions.
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  // Clears the byte-offset bits so every fetch address is word-aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: delivered instructions and downstream stall cycles.
// Both counters wrap at 2^32.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (i_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (i_stall_inc) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with single-outstanding imem requests and an
// IF/ID output register. FETCH_PERF_CNT_EN adds perf_fetch/perf_stall counters.
//   state | meaning
//   IDLE  | post-reset bubble, memory responses ignored
//   REQ   | request pc, wait for imem accept
//   WAIT  | request outstanding, wait for response (dropped if r_drop)
//   HOLD  | IF/ID register valid, wait for downstream id_ready
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_instr,
  output logic [6:0]  o_id_opcode,
  output logic [2:0]  o_id_funct3,
  output logic [6:0]  o_id_funct7
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_stall_cnt
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_drop;
  logic         r_id_valid;
  logic [31:0]  r_id_pc;
  logic [31:0]  r_id_instr;

  logic         w_redirect;
  logic [31:0]  w_redirect_pc;
  logic [31:0]  w_pc_next;

  assign w_redirect    = i_redirect_valid && (r_state != ST_IDLE);
  assign w_redirect_pc = word_align(i_redirect_pc);
  assign w_pc_next     = r_pc + PC_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= word_align(RESET_PC);
      r_drop     <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_pc    <= 32'd0;
      r_id_instr <= NOP_INSTR;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;

        ST_REQ: begin
          if (w_redirect) r_pc <= w_redirect_pc;
          if (i_imem_req_ready) begin
            r_state <= ST_WAIT;
            r_drop  <= w_redirect;
          end
        end

        // A redirect without a same-cycle response keeps waiting so the stale
        // response is absorbed here and only one request is ever outstanding.
        ST_WAIT: begin
          if (w_redirect) begin
            r_pc <= w_redirect_pc;
            if (i_imem_rsp_valid) begin
              r_drop  <= 1'b0;
              r_state <= ST_REQ;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (i_imem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= ST_REQ;
            end else begin
              r_id_instr <= i_imem_rsp_data;
              r_id_pc    <= r_pc;
              r_id_valid <= 1'b1;
              r_pc       <= w_pc_next;
              r_state    <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          if (w_redirect) begin
            r_pc       <= w_redirect_pc;
            r_id_valid <= 1'b0;
            r_state    <= ST_REQ;
          end else if (i_id_ready) begin
            r_id_valid <= 1'b0;
            r_state    <= ST_REQ;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_req_valid = (r_state == ST_REQ);
  assign o_imem_addr      = r_pc;
  assign o_id_valid       = r_id_valid;
  assign o_id_pc          = r_id_pc;
  assign o_id_instr       = r_id_instr;
  assign o_id_opcode      = r_id_instr[OPCODE_MSB:OPCODE_LSB];
  assign o_id_funct3      = r_id_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign o_id_funct7      = r_id_instr[FUNCT7_MSB:FUNCT7_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic w_fetch_inc;
  logic w_stall_inc;

  // A flushed instruction is not a delivered fetch even if id_ready was high.
  assign w_fetch_inc = r_id_valid && i_id_ready && !w_redirect;
  assign w_stall_inc = r_id_valid && !i_id_ready;

  fetch_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_fetch_inc (w_fetch_inc),
    .i_stall_inc (w_stall_inc),
    .o_fetch_cnt (o_perf_fetch_cnt),
    .o_stall_cnt (o_perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with an imem model that answers
// one cycle after accept and a scoreboard of expected IF/ID deliveries.
module tb_fetch_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_id_valid;
  logic        i_id_ready;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_instr;
  logic [6:0]  o_id_opcode;
  logic [2:0]  o_id_funct3;
  logic [6:0]  o_id_funct7;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_perf_fetch_cnt;
  logic [31:0] o_perf_stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        drop_next = 1'b0;
  logic [31:0] rsp_addr = 32'd0;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_id_valid       (o_id_valid),
    .i_id_ready       (i_id_ready),
    .o_id_pc          (o_id_pc),
    .o_id_instr       (o_id_instr),
    .o_id_opcode      (o_id_opcode),
    .o_id_funct3      (o_id_funct3),
    .o_id_funct7      (o_id_funct7)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt (o_perf_fetch_cnt),
    .o_perf_stall_cnt (o_perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score the current cycle, step the edge, then drive the memory response.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    exp_t        e;
    if (i_imem_rsp_valid) begin
      if (i_redirect_valid || drop_next) drop_next = 1'b0;
      else exp_q.push_back({rsp_addr, mem_word(rsp_addr)});
    end
    if (o_id_valid && i_redirect_valid) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (o_id_valid && i_id_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_id observed=%h expected=none", o_id_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_id_pc", o_id_pc, e.pc);
        chk("sb_id_instr", o_id_instr, e.instr);
        chk("sb_opcode", {25'd0, o_id_opcode}, {25'd0, e.instr[6:0]});
        chk("sb_funct3", {29'd0, o_id_funct3}, {29'd0, e.instr[14:12]});
        chk("sb_funct7", {25'd0, o_id_funct7}, {25'd0, e.instr[31:25]});
      end
    end
    chk("req_while_holding", {31'd0, o_imem_req_valid && o_id_valid}, 32'd0);
    acc = o_imem_req_valid && i_imem_req_ready;
    a   = o_imem_addr;
    @(posedge clk);
    #1;
    i_redirect_valid = 1'b0;
    i_imem_rsp_valid = acc;
    i_imem_rsp_data  = acc ? mem_word(a) : 32'd0;
    if (acc) rsp_addr = a;
  endtask

  task automatic wait_id();
    int n = 0;
    while (!o_id_valid && n < 20) begin
      cycle();
      n++;
    end
    chk("wait_id_timeout", {31'd0, o_id_valid}, 32'd1);
  endtask

  initial begin
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = 32'd0;
    i_redirect_valid = 1'b0;
    i_redirect_pc    = 32'd0;
    i_id_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'd0, o_id_valid}, 32'd0);
    chk("rst_id_pc", o_id_pc, 32'd0);
    chk("rst_id_instr", o_id_instr, 32'h0000_0013);
    chk("rst_opcode", {25'd0, o_id_opcode}, 32'h13);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", o_perf_fetch_cnt, 32'd0);
    chk("rst_perf_stall", o_perf_stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // first fetch from RESET_PC
    cycle();
    chk("first_req_valid", {31'd0, o_imem_req_valid}, 32'd1);
    chk("first_addr", o_imem_addr, 32'd0);
    cycle();
    cycle();
    chk("first_id_valid", {31'd0, o_id_valid}, 32'd1);
    chk("first_id_pc", o_id_pc, 32'd0);
    chk("first_id_instr", o_id_instr, 32'h0010_0093);
    chk("first_opcode", {25'd0, o_id_opcode}, 32'h13);
    chk("first_funct3", {29'd0, o_id_funct3}, 32'd0);

    // downstream stall
    repeat (5) begin
      cycle();
      chk("stall_id_valid", {31'd0, o_id_valid}, 32'd1);
      chk("stall_id_pc", o_id_pc, 32'd0);
      chk("stall_id_instr", o_id_instr, 32'h0010_0093);
      chk("stall_no_req", {31'd0, o_imem_req_valid}, 32'd0);
    end
    i_id_ready = 1'b1;
    cycle();
    chk("next_req_valid", {31'd0, o_imem_req_valid}, 32'd1);
    chk("next_addr_4", o_imem_addr, 32'd4);

    // zero-wait throughput: request t, id_valid t+2, next request t+3
    cycle();
    chk("tp_wait_no_id", {31'd0, o_id_valid}, 32'd0);
    chk("tp_wait_no_req", {31'd0, o_imem_req_valid}, 32'd0);
    cycle();
    chk("tp_id_valid", {31'd0, o_id_valid}, 32'd1);
    chk("tp_id_pc", o_id_pc, 32'd4);
    cycle();
    chk("tp_next_req", {31'd0, o_imem_req_valid}, 32'd1);
    chk("tp_next_addr", o_imem_addr, 32'd8);

    // redirect in WAIT with same-cycle response
    cycle();
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0000_0102;
    cycle();
    chk("wait_redir_req", {31'd0, o_imem_req_valid}, 32'd1);
    chk("wait_redir_addr", o_imem_addr, 32'h0000_0100);
    chk("wait_redir_no_id", {31'd0, o_id_valid}, 32'd0);
    cycle();
    chk("wait_redir_no_stale", {31'd0, o_id_valid}, 32'd0);
    wait_id();
    chk("redir_target_pc", o_id_pc, 32'h0000_0100);
    cycle();

    // redirect in HOLD with id_ready=1 flushes
    wait_id();
    chk("hold_pc", o_id_pc, 32'h0000_0104);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0000_0200;
    cycle();
    chk("hold_flush_id", {31'd0, o_id_valid}, 32'd0);
    chk("hold_redir_addr", o_imem_addr, 32'h0000_0200);
    chk("hold_redir_req", {31'd0, o_imem_req_valid}, 32'd1);

    // redirect in REQ accepted the same cycle
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0000_0300;
    drop_next        = 1'b1;
    cycle();
    chk("req_acc_redir_wait", {31'd0, o_imem_req_valid}, 32'd0);
    cycle();
    chk("req_acc_redir_addr", o_imem_addr, 32'h0000_0300);
    chk("req_acc_redir_req", {31'd0, o_imem_req_valid}, 32'd1);
    chk("req_acc_redir_no_id", {31'd0, o_id_valid}, 32'd0);

    // back-pressure in REQ, then redirect there to the top word
    i_imem_req_ready = 1'b0;
    cycle();
    chk("bp_addr_held", o_imem_addr, 32'h0000_0300);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFF;
    cycle();
    chk("bp_redir_addr", o_imem_addr, 32'hFFFF_FFFC);
    i_imem_req_ready = 1'b1;
    wait_id();
    chk("top_word_pc", o_id_pc, 32'hFFFF_FFFC);
    cycle();
    chk("wrap_addr", o_imem_addr, 32'd0);

    // async reset mid-WAIT with a response pending across release
    i_imem_req_ready = 1'b0;
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h0000_0500;
    cycle();
    i_imem_req_ready = 1'b1;
    cycle();
    drop_next = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_id_valid", {31'd0, o_id_valid}, 32'd0);
    chk("arst_id_instr", o_id_instr, 32'h0000_0013);
    chk("arst_req_valid", {31'd0, o_imem_req_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_perf_fetch", o_perf_fetch_cnt, 32'd0);
    chk("arst_perf_stall", o_perf_stall_cnt, 32'd0);
`endif
    #1 rst_n = 1'b1;
    cycle();
    chk("post_rst_addr", o_imem_addr, 32'd0);
    chk("post_rst_req", {31'd0, o_imem_req_valid}, 32'd1);
    chk("post_rst_no_id", {31'd0, o_id_valid}, 32'd0);

    // ten deliveries with three stall cycles on the fourth
    for (int i = 0; i < 10; i++) begin
      i_id_ready = (i != 3);
      wait_id();
      if (i == 3) begin
        repeat (3) cycle();
        i_id_ready = 1'b1;
      end
      cycle();
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_10", o_perf_fetch_cnt, 32'd10);
    chk("perf_stall_3", o_perf_stall_cnt, 32'd3);
`endif
    chk("last_addr", o_imem_addr, 32'd40);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
